menu_cmd_encoder: RTL

//  Input end of the ATM menu path: conditions the raw board buttons and encodes them into

---
 rtl/menu_pkg.sv | 25 ++
 rtl/btn_conditioner.sv | 50 +++++
 rtl/menu_cmd_encoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/menu_pkg.sv
// Shared command codes, FSM encoding and event priority for the menu input path.
package menu_pkg;

  localparam int unsigned CMD_W = 2;

  localparam logic [CMD_W-1:0] CMD_BACK = 2'b00;
  localparam logic [CMD_W-1:0] CMD_UP   = 2'b01;
  localparam logic [CMD_W-1:0] CMD_DOWN = 2'b10;
  localparam logic [CMD_W-1:0] CMD_SEL  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  // Priority select among same-cycle events: select > back > up > down
  function automatic logic [CMD_W-1:0] pick_cmd(input logic evt_c, input logic evt_l,
                                                 input logic evt_u);
    if (evt_c)      return CMD_SEL;
    else if (evt_l) return CMD_BACK;
    else if (evt_u) return CMD_UP;
    else            return CMD_DOWN;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One raw button: 2-FF synchroniser, stable-time debounce, registered rising-edge pulse.
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from the stable one long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/menu_cmd_encoder.sv
// Button conditioning, auto-repeat and command handshake; owns the menu selection.
module menu_cmd_encoder
  import menu_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned REPEAT_CYCLES = 50_000_000,
  parameter int unsigned N_ITEMS       = 4,
  parameter int unsigned SEL_W         = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               BTNU,
  input  logic               BTND,
  input  logic               BTNC,
  input  logic               BTNL,
  output logic               cmd_valid,
  output logic [CMD_W-1:0]   cmd_code,
  input  logic               cmd_ready,
  output logic [SEL_W-1:0]   sel,
  output logic [N_ITEMS-1:0] item_rst,
  output logic               evt_drop
);

  localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_ITEMS - 1);

  // index 0 = up, 1 = down
  logic [1:0]       ud_level;
  logic [1:0]       ud_press;
  logic [1:0]       ud_rpt;
  logic [RPT_W-1:0] rpt_cnt [2];
  logic             press_c;
  logic             press_l;
  logic             unused_level_c;
  logic             unused_level_l;

  logic             evt_u;
  logic             evt_d;
  logic             any_evt;
  state_t           state;
  state_t           state_nxt;
  logic             drop_nxt;
  logic [CMD_W-1:0] code_nxt;
  logic [SEL_W-1:0] sel_nxt;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_u (
    .clk(clk), .rst_n(rst_n), .raw(BTNU), .level(ud_level[0]), .press(ud_press[0]));
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_d (
    .clk(clk), .rst_n(rst_n), .raw(BTND), .level(ud_level[1]), .press(ud_press[1]));
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_c (
    .clk(clk), .rst_n(rst_n), .raw(BTNC), .level(unused_level_c), .press(press_c));
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_l (
    .clk(clk), .rst_n(rst_n), .raw(BTNL), .level(unused_level_l), .press(press_l));

  // Auto-repeat: pulse every REPEAT_CYCLES while up/down is held, counted from the press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ud_rpt <= '0;
      for (int i = 0; i < 2; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        ud_rpt[i] <= 1'b0;
        if (!ud_level[i]) begin
          rpt_cnt[i] <= '0;
        end else if (rpt_cnt[i] == RPT_LAST) begin
          rpt_cnt[i] <= '0;
          ud_rpt[i]  <= 1'b1;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
        end
      end
    end
  end

  assign evt_u   = ud_press[0] | ud_rpt[0];
  assign evt_d   = ud_press[1] | ud_rpt[1];
  assign any_evt = press_c | press_l | evt_u | evt_d;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: load on an event when idle, leave on handshake
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_evt) state_nxt = ST_PEND;
      ST_PEND: if (cmd_valid && cmd_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: next command code, next selection, drop indication
  always_comb begin
    drop_nxt = 1'b0;
    code_nxt = cmd_code;
    sel_nxt  = sel;
    if (any_evt) begin
      if (state == ST_IDLE) begin
        code_nxt = pick_cmd(press_c, press_l, evt_u);
        if (code_nxt == CMD_UP) begin
          sel_nxt = (sel == '0) ? SEL_LAST : sel - SEL_W'(1);
        end else if (code_nxt == CMD_DOWN) begin
          sel_nxt = (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
        end
      end else begin
        drop_nxt = 1'b1;
      end
    end
  end

  // Registered command, selection and one-cold item reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_code  <= CMD_BACK;
      sel       <= '0;
      item_rst  <= ~N_ITEMS'(1);
      evt_drop  <= 1'b0;
    end else begin
      cmd_valid <= (state_nxt == ST_PEND);
      cmd_code  <= code_nxt;
      sel       <= sel_nxt;
      item_rst  <= ~(N_ITEMS'(1) << sel_nxt);
      evt_drop  <= drop_nxt;
    end
  end

endmodule
